regfile_wb_scheduler: RTL

- Owns the single register-file write port.
- Arbitrates that port between the in-order pipeline writeback and the long-latency unit (mul/div), which uses a valid/ready handshake.
- Keeps a scoreboard of destinations with pending long-latency writes and stalls decode on RAW/WAW hazards against them.
- Sits between decode/writeback and the register file; its rf_* outputs drive the register file write inputs directly.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 78 +++++++
 rtl/regfile_wb_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the register-file writeback
//               scheduler and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_N_WORDS    = 32;
    localparam int DEF_AW         = $clog2(DEF_N_WORDS);

    typedef logic [DEF_AW-1:0]         reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Busy vector and pending counter for long-latency destinations,
//               with hazard lookups for the three decode register indices.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int N_WORDS     = DEF_N_WORDS,
    parameter int MAX_PENDING = 4,
    parameter int AW          = $clog2(N_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_set_en,
    input  logic [AW-1:0]      i_set_idx,
    input  logic               i_clr_en,
    input  logic [AW-1:0]      i_clr_idx,
    input  logic [AW-1:0]      i_rs_idx,
    input  logic [AW-1:0]      i_rt_idx,
    input  logic [AW-1:0]      i_rd_idx,
    output logic               o_rs_busy,
    output logic               o_rt_busy,
    output logic               o_rd_busy,
    output logic               o_full,
    output logic [N_WORDS-1:0] o_busy
);

    localparam int            PW     = $clog2(MAX_PENDING + 1);
    localparam logic [AW-1:0] c_zero = AW'(REG_ZERO);

    logic [N_WORDS-1:0] r_busy;
    logic [PW-1:0]      r_pending;
    logic [N_WORDS-1:0] w_busy_next;
    logic               w_do_set;
    logic               w_do_clr;

    function automatic logic lookup(input logic [N_WORDS-1:0] vec,
                                    input logic [AW-1:0]      idx);
        return vec[idx];
    endfunction

    // Only real transitions count, so pending always tracks popcount(busy);
    // a clear to a non-busy register (protocol error) changes nothing.
    assign w_do_set = i_set_en && (i_set_idx != c_zero) && !lookup(r_busy, i_set_idx);
    assign w_do_clr = i_clr_en && lookup(r_busy, i_clr_idx);

    always_comb begin
        w_busy_next = r_busy;
        if (w_do_set) w_busy_next[i_set_idx] = 1'b1;
        if (w_do_clr) w_busy_next[i_clr_idx] = 1'b0;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy <= w_busy_next;
            case ({w_do_set, w_do_clr})
                2'b10:   r_pending <= r_pending + PW'(1);
                2'b01:   r_pending <= r_pending - PW'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign o_rs_busy = lookup(r_busy, i_rs_idx);
    assign o_rt_busy = lookup(r_busy, i_rt_idx);
    assign o_rd_busy = lookup(r_busy, i_rd_idx);
    assign o_full    = (r_pending == PW'(MAX_PENDING));
    assign o_busy    = r_busy;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Arbitrates the single register-file write port between the
//               pipeline writeback and the LLU, and stalls decode on hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int N_WORDS      = DEF_N_WORDS,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = $clog2(N_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rs,
    input  logic [AW-1:0]         iss_rt,
    input  logic                  iss_uses_rt,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  iss_wr,
    input  logic                  iss_long,
    output logic                  iss_stall,
    input  logic                  pwb_we,
    input  logic [AW-1:0]         pwb_rd,
    input  logic [DATA_WIDTH-1:0] pwb_d,
    input  logic                  llu_valid,
    input  logic [AW-1:0]         llu_rd,
    input  logic [DATA_WIDTH-1:0] llu_d,
    output logic                  llu_ready,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_rd,
    output logic [DATA_WIDTH-1:0] rf_d,
    output logic [N_WORDS-1:0]    sb_busy
);

    localparam int            SW     = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] c_zero = AW'(REG_ZERO);

    logic          r_starve_cnt_unused_guard;
    logic [SW-1:0] r_starve_cnt;
    logic          w_pwb_real;
    logic          w_llu_acc;
    logic          w_starve_force;
    logic          w_rs_busy;
    logic          w_rt_busy;
    logic          w_rd_busy;
    logic          w_full;
    logic          w_iss_acc;

    assign r_starve_cnt_unused_guard = 1'b0;

    // Outputs are gated by rst so the port is quiet for the whole reset pulse.
    assign w_pwb_real = pwb_we && (pwb_rd != c_zero);
    assign llu_ready  = !rst && !w_pwb_real;
    assign w_llu_acc  = llu_valid && llu_ready;

    always_comb begin
        rf_we = 1'b0;
        rf_rd = '0;
        rf_d  = '0;
        if (!rst) begin
            if (w_pwb_real) begin
                rf_we = 1'b1;
                rf_rd = pwb_rd;
                rf_d  = pwb_d;
            end else if (w_llu_acc) begin
                rf_we = (llu_rd != c_zero);
                rf_rd = llu_rd;
                rf_d  = llu_d;
            end
        end
    end

    // Counts consecutive refused LLU cycles; saturation forces decode bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (llu_valid && !llu_ready) begin
            if (r_starve_cnt != SW'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + SW'(1);
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign w_starve_force = (r_starve_cnt == SW'(STARVE_LIMIT));

    assign iss_stall = !rst && iss_valid &&
                       (w_rs_busy ||
                        (iss_uses_rt && w_rt_busy) ||
                        (iss_wr && w_rd_busy) ||
                        (iss_long && w_full) ||
                        w_starve_force ||
                        r_starve_cnt_unused_guard);

    assign w_iss_acc = iss_valid && !iss_stall;

    regfile_scoreboard #(
        .N_WORDS     (N_WORDS),
        .MAX_PENDING (MAX_PENDING),
        .AW          (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set_en  (w_iss_acc && iss_long && iss_wr),
        .i_set_idx (iss_rd),
        .i_clr_en  (w_llu_acc),
        .i_clr_idx (llu_rd),
        .i_rs_idx  (iss_rs),
        .i_rt_idx  (iss_rt),
        .i_rd_idx  (iss_rd),
        .o_rs_busy (w_rs_busy),
        .o_rt_busy (w_rt_busy),
        .o_rd_busy (w_rd_busy),
        .o_full    (w_full),
        .o_busy    (sb_busy)
    );

endmodule : regfile_wb_scheduler
`default_nettype wire
